hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Each cycle it decides the pipeline's stall, flush and freeze controls:
- load-use stalls, which the forwarding unit cannot resolve;
- taken-branch flushes resolved in EX;
- multi-cycle data-memory freezes through a req/ready handshake, with a timeout into a sticky halt.

It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes. It also keeps a saturating stall-cycle counter for performance readout.

---
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_controller.sv | 130 +++++++++++++
 tb/tb_hazard_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline hazard bus: hazard inputs from the pipeline, stall/flush/freeze controls back.
interface hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             IDEXmemRead;
    logic [4:0]       IDEXrt;
    logic [4:0]       IFIDrs;
    logic [4:0]       IFIDrt;
    logic             IFIDusesRt;
    logic             EXbranchTaken;
    logic             EXMEMmemAccess;
    logic             memReady;
    logic             pcWrite;
    logic             IFIDwrite;
    logic             IFIDflush;
    logic             IDEXflush;
    logic             IDEXhold;
    logic             EXMEMhold;
    logic             MEMWBbubble;
    logic             memReq;
    logic             memErr;
    logic [CNT_W-1:0] stallCount;

    // Controller side
    modport master (
        input  IDEXmemRead, IDEXrt, IFIDrs, IFIDrt, IFIDusesRt,
               EXbranchTaken, EXMEMmemAccess, memReady,
        output pcWrite, IFIDwrite, IFIDflush, IDEXflush, IDEXhold,
               EXMEMhold, MEMWBbubble, memReq, memErr, stallCount
    );

    // Pipeline side
    modport slave (
        output IDEXmemRead, IDEXrt, IFIDrs, IFIDrt, IFIDusesRt,
               EXbranchTaken, EXMEMmemAccess, memReady,
        input  pcWrite, IFIDwrite, IFIDflush, IDEXflush, IDEXhold,
               EXMEMhold, MEMWBbubble, memReq, memErr, stallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch
// flushes, data-memory freezes with timeout into a sticky halt, and a
// saturating stall-cycle counter.
module hazard_controller #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.master bus
);
    localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic mem_stall_c;
    logic load_use_c;
    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic idex_hold_c;
    logic exmem_hold_c;
    logic memwb_bubble_c;
    logic mem_req_c;

    // Raw hazard conditions from the current pipeline contents
    always_comb begin
        mem_stall_c = bus.EXMEMmemAccess && !bus.memReady;
        load_use_c  = bus.IDEXmemRead && (bus.IDEXrt != 5'd0) &&
                      ((bus.IDEXrt == bus.IFIDrs) ||
                       (bus.IFIDusesRt && (bus.IDEXrt == bus.IFIDrt)));
    end

    // Mealy control outputs and next-state selection; freeze beats branch beats load-use
    always_comb begin
        pc_write_c     = 1'b0;
        ifid_write_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_flush_c   = 1'b0;
        idex_hold_c    = 1'b0;
        exmem_hold_c   = 1'b0;
        memwb_bubble_c = 1'b0;
        mem_req_c      = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;

        if (rst) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else begin
            case (state_q)
                HALT: begin
                    idex_hold_c    = 1'b1;
                    exmem_hold_c   = 1'b1;
                    memwb_bubble_c = 1'b1;
                end
                default: begin
                    mem_req_c = bus.EXMEMmemAccess;
                    if (mem_stall_c) begin
                        idex_hold_c    = 1'b1;
                        exmem_hold_c   = 1'b1;
                        memwb_bubble_c = 1'b1;
                        if (state_q == RUN) begin
                            state_d    = MEM_WAIT;
                            wait_cnt_d = WAIT_W'(1);
                        end else if (wait_cnt_q >= TIMEOUT_W) begin
                            state_d = HALT;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                        if (bus.EXbranchTaken) begin
                            pc_write_c   = 1'b1;
                            ifid_write_c = 1'b1;
                            ifid_flush_c = 1'b1;
                            idex_flush_c = 1'b1;
                        end else if (load_use_c) begin
                            idex_flush_c = 1'b1;
                        end else begin
                            pc_write_c   = 1'b1;
                            ifid_write_c = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, wait counter, sticky error flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= (state_d == HALT);
            if (!pc_write_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pcWrite     = pc_write_c;
    assign bus.IFIDwrite   = ifid_write_c;
    assign bus.IFIDflush   = ifid_flush_c;
    assign bus.IDEXflush   = idex_flush_c;
    assign bus.IDEXhold    = idex_hold_c;
    assign bus.EXMEMhold   = exmem_hold_c;
    assign bus.MEMWBbubble = memwb_bubble_c;
    assign bus.memReq      = mem_req_c;
    assign bus.memErr      = mem_err_q;
    assign bus.stallCount  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller with TIMEOUT=4, CNT_W=3.
// Control word order: {pcWrite, IFIDwrite, IFIDflush, IDEXflush, IDEXhold,
//                      EXMEMhold, MEMWBbubble, memReq, memErr}
module tb_hazard_controller;
    localparam logic [8:0] C_RUN   = 9'h180;
    localparam logic [8:0] C_ACC   = 9'h182;
    localparam logic [8:0] C_LU    = 9'h020;
    localparam logic [8:0] C_BR    = 9'h1E0;
    localparam logic [8:0] C_BRACC = 9'h1E2;
    localparam logic [8:0] C_FRZ   = 9'h01E;
    localparam logic [8:0] C_HLT   = 9'h01D;
    localparam logic [8:0] C_RST   = 9'h060;

    typedef struct {
        logic       rst;
        logic       rd;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [8:0] ctrl;
        logic [2:0] cnt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [8:0] ctrl;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   step = 0;
    exp_t exp_q[$];

    hazard_if #(.CNT_W(3)) hif ();

    hazard_controller #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rd, input logic [4:0] ex_rt,
                                input logic [4:0] id_rs, input logic [4:0] id_rt,
                                input logic uses_rt, input logic br, input logic acc,
                                input logic rdy, input logic [8:0] ctrl, input logic [2:0] cnt);
        vec_t v;
        v.rst = r; v.rd = rd; v.ex_rt = ex_rt; v.id_rs = id_rs; v.id_rt = id_rt;
        v.uses_rt = uses_rt; v.br = br; v.acc = acc; v.rdy = rdy;
        v.ctrl = ctrl; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of stimulus just after the edge and queue its expectation
    task automatic apply(input vec_t v);
        exp_t e;
        rst                = v.rst;
        hif.IDEXmemRead    = v.rd;
        hif.IDEXrt         = v.ex_rt;
        hif.IFIDrs         = v.id_rs;
        hif.IFIDrt         = v.id_rt;
        hif.IFIDusesRt     = v.uses_rt;
        hif.EXbranchTaken  = v.br;
        hif.EXMEMmemAccess = v.acc;
        hif.memReady       = v.rdy;
        e.idx  = step;
        e.ctrl = v.ctrl;
        e.cnt  = v.cnt;
        exp_q.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop and compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e = exp_q.pop_front();
            act = {hif.pcWrite, hif.IFIDwrite, hif.IFIDflush, hif.IDEXflush, hif.IDEXhold,
                   hif.EXMEMhold, hif.MEMWBbubble, hif.memReq, hif.memErr};
            checks++;
            if (act !== e.ctrl) begin
                failures++;
                $display("FAIL ctrl step=%0d got=%09b want=%09b", e.idx, act, e.ctrl);
            end
            checks++;
            if (hif.stallCount !== e.cnt) begin
                failures++;
                $display("FAIL stallCount step=%0d got=%0d want=%0d", e.idx, hif.stallCount, e.cnt);
            end
        end
    end

    initial begin
        vec_t tbl[10];
        int   left;

        hif.IDEXmemRead = 1'b0; hif.IDEXrt = '0; hif.IFIDrs = '0; hif.IFIDrt = '0;
        hif.IFIDusesRt = 1'b0; hif.EXbranchTaken = 1'b0; hif.EXMEMmemAccess = 1'b0;
        hif.memReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single-cycle decision vectors
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);
        tbl[2] = mk(0, 1, 8, 8, 0, 0, 0, 0, 0, C_LU,  0);
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1);
        tbl[4] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1);
        tbl[5] = mk(0, 1, 8, 3, 8, 0, 0, 0, 0, C_RUN, 1);
        tbl[6] = mk(0, 1, 8, 3, 8, 1, 0, 0, 0, C_LU,  1);
        tbl[7] = mk(0, 1, 8, 8, 0, 0, 1, 0, 0, C_BR,  2);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ACC, 2);
        for (int i = 0; i < 10; i++) apply(tbl[i]);

        // Three-cycle memory wait, then ready
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 3));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 4));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ACC, 5));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 5));

        // Freeze beats branch; flush lands in the ready cycle
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 5));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_BRACC, 2));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2));

        // Access dropped while waiting returns to RUN and applies the rules
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2));
        apply(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, C_LU,  3));

        // Timeout: five unready cycles from RUN, then halted
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 4));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 5));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 6));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_HLT, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_HLT, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_HLT, 7));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST | 9'h001, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0));

        // Saturation over ten consecutive load-use stalls
        for (int k = 0; k < 10; k++) begin
            left = (k > 7) ? 7 : k;
            apply(mk(0, 1, 9, 9, 0, 0, 0, 0, 0, C_LU, 3'(left)));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 7));

        // Reset mid-wait discards the pending access
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 7));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 7));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ACC, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 1));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
